divisor_feeder: RTL and testbench

Upstream issue stage for the algorithmic divider. Accepts signed operand pairs on a valid/ready stream, buffers them in a small FIFO, and issues one division at a time with a single-cycle `Start`. Holds `Num`/`Den` stable until `Done`, then presents `Coc`/`Res` on a valid/ready result stream. Divide-by-zero is intercepted locally and a watchdog bounds the wait for `Done`.

---
 rtl/divisor_feeder_pkg.sv | 11 +
 rtl/divisor_feeder_fifo.sv | 40 ++++
 rtl/divisor_feeder.sv | 96 +++++++++
 tb/tb_divisor_feeder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_feeder_pkg.sv
// divisor_feeder_pkg: shared types and default sizing for the divider issue stage.
package divisor_feeder_pkg;
   localparam int DATA_W      = 32;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_TIMEOUT = 256;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} feed_state_t;
   typedef struct packed {
      logic [DATA_W-1:0] num;
      logic [DATA_W-1:0] den;
   } operand_t;
endpackage

// File: rtl/divisor_feeder_fifo.sv
// divisor_feeder_fifo: synchronous operand FIFO with wrap-around pointers and an occupancy count.
module divisor_feeder_fifo
   import divisor_feeder_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  logic     pop,
   input  operand_t din,
   output operand_t dout,
   output logic     full,
   output logic     empty
);
   localparam int AW = $clog2(DEPTH);
   operand_t mem [DEPTH];
   logic [AW-1:0] wr, rd;
   logic [AW:0] count;
   logic wr_en, rd_en;
   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign dout  = mem[rd];
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr] <= din;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else begin
         wr    <= wr + AW'(wr_en);
         rd    <= rd + AW'(rd_en);
         count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end
   end
endmodule

// File: rtl/divisor_feeder.sv
// divisor_feeder: queues signed operand pairs and issues them one at a time to the divider,
// intercepting divide-by-zero and bounding the wait for Done with a watchdog.
module divisor_feeder
   import divisor_feeder_pkg::*;
#(
   parameter int tamanyo = DATA_W,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic               CLK,
   input  logic               RSTa,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [tamanyo-1:0] in_num,
   input  logic [tamanyo-1:0] in_den,
   output logic               Start,
   output logic [tamanyo-1:0] Num,
   output logic [tamanyo-1:0] Den,
   input  logic [tamanyo-1:0] Coc,
   input  logic [tamanyo-1:0] Res,
   input  logic               Done,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [tamanyo-1:0] out_coc,
   output logic [tamanyo-1:0] out_res,
   output logic               out_div0,
   output logic               out_err
);
   localparam int WW = $clog2(TIMEOUT) + 1;
   feed_state_t state, next;
   operand_t din, head;
   logic full, empty, pop, expire, div0;
   logic [WW-1:0] wd;
   assign din       = '{num: in_num, den: in_den};
   assign in_ready  = !full;
   assign Start     = state == ISSUE;
   assign out_valid = state == HOLD;
   assign div0      = head.den == '0;
   // Expire when this cycle's increment lands on TIMEOUT-1, so the forced result is TIMEOUT cycles after Start.
   assign expire    = wd == WW'(TIMEOUT - 2);
   divisor_feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(CLK), .rst_n(RSTa), .push(in_valid), .pop(pop),
      .din(din), .dout(head), .full(full), .empty(empty)
   );
   always_comb begin
      next = state;
      pop  = 1'b0;
      case (state)
         IDLE: if (!empty) begin
            pop  = 1'b1;
            next = div0 ? HOLD : ISSUE;
         end
         ISSUE:   next = WAIT;
         WAIT:    next = Done || expire ? HOLD : WAIT;
         HOLD:    next = out_ready ? IDLE : HOLD;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (!RSTa) state <= IDLE;
      else state <= next;
   end
   always_ff @(posedge CLK) begin
      if (!RSTa) begin
         wd       <= '0;
         Num      <= '0;
         Den      <= '0;
         out_coc  <= '0;
         out_res  <= '0;
         out_div0 <= 1'b0;
         out_err  <= 1'b0;
      end else begin
         wd <= state == WAIT ? wd + 1'b1 : '0;
         if (pop && !div0) begin
            Num <= head.num;
            Den <= head.den;
         end
         if (pop && div0) begin
            out_coc  <= '1;
            out_res  <= head.num;
            out_div0 <= 1'b1;
            out_err  <= 1'b0;
         end else if (state == WAIT && Done) begin
            out_coc  <= Coc;
            out_res  <= Res;
            out_div0 <= 1'b0;
            out_err  <= 1'b0;
         end else if (state == WAIT && expire) begin
            out_coc  <= '0;
            out_res  <= '0;
            out_div0 <= 1'b0;
            out_err  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_divisor_feeder.sv
// tb_divisor_feeder: directed bench with a queue-based result model and an attached divider model.
module tb_divisor_feeder;
   logic CLK = 0, RSTa = 0, in_valid = 0, out_ready = 0, Done = 0;
   logic [31:0] in_num = 0, in_den = 0, Coc = 0, Res = 0;
   logic in_ready, Start, out_valid, out_div0, out_err;
   logic [31:0] Num, Den, out_coc, out_res;
   typedef struct { logic [31:0] coc; logic [31:0] res; logic div0; logic err; } res_t;
   res_t expq[$];
   res_t e;
   int checks = 0, errors = 0, cyc = 0, starts = 0, start_cyc = 0, push_cyc = 0, lat = 3, cnt = -1;
   bit div_en = 1, stray = 0, stab = 1;
   logic [31:0] dn = 0, dd = 0;

   divisor_feeder dut (
      .CLK(CLK), .RSTa(RSTa), .in_valid(in_valid), .in_ready(in_ready),
      .in_num(in_num), .in_den(in_den), .Start(Start), .Num(Num), .Den(Den),
      .Coc(Coc), .Res(Res), .Done(Done), .out_valid(out_valid), .out_ready(out_ready),
      .out_coc(out_coc), .out_res(out_res), .out_div0(out_div0), .out_err(out_err)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic res_t model(input logic [31:0] n, input logic [31:0] d);
      res_t r;
      r.div0 = 0;
      r.err  = 0;
      if (d == 0) begin
         r.coc  = 32'hFFFFFFFF;
         r.res  = n;
         r.div0 = 1;
      end else if (!div_en) begin
         r.coc = 0;
         r.res = 0;
         r.err = 1;
      end else begin
         r.coc = $signed(n) / $signed(d);
         r.res = $signed(n) % $signed(d);
      end
      return r;
   endfunction

   task automatic push(input logic [31:0] n, input logic [31:0] d, output bit acc);
      @(negedge CLK);
      in_valid = 1;
      in_num   = n;
      in_den   = d;
      #1;
      acc      = in_ready;
      push_cyc = cyc + 1;
      if (acc) expq.push_back(model(n, d));
      @(posedge CLK);
      #1 in_valid = 0;
   endtask

   task automatic wait_valid(input string name, input int lim);
      for (int i = 0; i < lim; i++) begin
         @(negedge CLK);
         #3;
         if (out_valid) break;
      end
      chk(name, 32'(out_valid), 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_start"}, 32'(Start), 0);
      chk({tag, "_valid"}, 32'(out_valid), 0);
      chk({tag, "_num"}, Num, 0);
      chk({tag, "_den"}, Den, 0);
      chk({tag, "_coc"}, out_coc, 0);
      chk({tag, "_res"}, out_res, 0);
      chk({tag, "_div0"}, 32'(out_div0), 0);
      chk({tag, "_err"}, 32'(out_err), 0);
      chk({tag, "_in_ready"}, 32'(in_ready), 1);
   endtask

   // Divider model: latches operands on Start, answers after lat cycles, checks operands stay stable.
   always @(negedge CLK) begin
      #1;
      Done = 0;
      if (Start === 1'b1) begin
         dn = Num;
         dd = Den;
         cnt = lat;
         starts++;
         start_cyc = cyc;
      end else if (cnt > 0) begin
         cnt--;
         if (stab) begin
            chk("num_stable", Num, dn);
            chk("den_stable", Den, dd);
         end
         if (cnt == 0) begin
            Done = div_en;
            Coc  = $signed(dn) / $signed(dd);
            Res  = $signed(dn) % $signed(dd);
            cnt  = -1;
         end
      end
      if (stray) begin
         Done = 1;
         Coc  = 123;
         Res  = 456;
      end
   end

   // Result scoreboard: every accepted result must match the oldest accepted operand pair.
   always @(negedge CLK) begin
      #2;
      if (RSTa && out_valid && out_ready) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got result coc=%h res=%h expected none", out_coc, out_res);
         end else begin
            e = expq.pop_front();
            chk("sb_coc", out_coc, e.coc);
            chk("sb_res", out_res, e.res);
            chk("sb_div0", 32'(out_div0), 32'(e.div0));
            chk("sb_err", 32'(out_err), 32'(e.err));
         end
      end
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL global_timeout: got no finish expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      bit acc, bad;
      int n_acc, s;
      logic [31:0] cap_n [7];
      logic [31:0] cap_d [7];
      cap_n = '{1000, -1000, 1000, 37, -1, 8, 9};
      cap_d = '{7, 7, -7, 0, 5, 8, 9};
      repeat (2) @(negedge CLK);
      #3 chk_zero("reset");
      RSTa = 1;
      @(negedge CLK);
      #3 chk("in_ready_after_reset", 32'(in_ready), 1);

      // 100 / 7
      @(negedge CLK);
      out_ready = 1;
      push(100, 7, acc);
      wait_valid("t1_valid", 20);
      chk("t1_start_lat", start_cyc, push_cyc + 1);
      chk("t1_valid_lat", cyc - start_cyc, lat + 1);
      chk("t1_coc", out_coc, 14);
      chk("t1_res", out_res, 2);
      chk("t1_div0", 32'(out_div0), 0);
      chk("t1_err", 32'(out_err), 0);

      // -7 / 2, held until accepted
      @(negedge CLK);
      out_ready = 0;
      push(-7, 2, acc);
      wait_valid("t2_valid", 20);
      chk("t2_coc", out_coc, 32'hFFFFFFFD);
      chk("t2_res", out_res, 32'hFFFFFFFF);
      repeat (4) @(negedge CLK);
      #3;
      chk("t2_hold_valid", 32'(out_valid), 1);
      chk("t2_hold_coc", out_coc, 32'hFFFFFFFD);
      @(negedge CLK);
      out_ready = 1;
      @(negedge CLK);
      out_ready = 0;
      #3 chk("t2_released", 32'(out_valid), 0);

      // 55 / 0 intercepted
      s = starts;
      push(55, 0, acc);
      @(negedge CLK);
      #3 chk("t3_early", 32'(out_valid), 0);
      @(negedge CLK);
      #3;
      chk("t3_valid", 32'(out_valid), 1);
      chk("t3_coc", out_coc, 32'hFFFFFFFF);
      chk("t3_res", out_res, 55);
      chk("t3_div0", 32'(out_div0), 1);
      chk("t3_err", 32'(out_err), 0);
      chk("t3_no_start", starts, s);
      @(negedge CLK);
      out_ready = 1;
      @(negedge CLK);
      out_ready = 0;

      // capacity with the consumer stalled
      n_acc = 0;
      for (int i = 0; i < 7; i++) begin
         push(cap_n[i], cap_d[i], acc);
         n_acc += int'(acc);
      end
      @(negedge CLK);
      #3;
      chk("t4_accepted", n_acc, 5);
      chk("t4_in_ready", 32'(in_ready), 0);
      @(negedge CLK);
      out_ready = 1;
      for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge CLK);
      #3 chk("t4_drained", expq.size(), 0);

      // watchdog: divider never answers
      @(negedge CLK);
      out_ready = 0;
      div_en = 0;
      push(9, 3, acc);
      wait_valid("t5_valid", 400);
      chk("t5_latency", cyc - start_cyc, 256);
      chk("t5_err", 32'(out_err), 1);
      chk("t5_coc", out_coc, 0);
      chk("t5_res", out_res, 0);
      chk("t5_div0", 32'(out_div0), 0);
      @(negedge CLK);
      stray = 1;
      @(negedge CLK);
      stray = 0;
      #3;
      chk("t5_stray_hold_coc", out_coc, 0);
      chk("t5_stray_hold_err", 32'(out_err), 1);
      @(negedge CLK);
      out_ready = 1;
      @(negedge CLK);
      stray = 1;
      @(negedge CLK);
      stray = 0;
      bad = 0;
      repeat (4) begin
         @(negedge CLK);
         #3 bad |= out_valid;
      end
      chk("t5_stray_idle", 32'(bad), 0);
      div_en = 1;

      // reset while waiting with three entries queued
      @(negedge CLK);
      lat = 6;
      for (int i = 1; i <= 4; i++) push(10 * i, 3, acc);
      @(negedge CLK);
      stab = 0;
      RSTa = 0;
      expq.delete();
      @(negedge CLK);
      RSTa = 1;
      #3 chk_zero("midreset");
      bad = 0;
      repeat (10) begin
         @(negedge CLK);
         #3 bad |= out_valid | Start;
      end
      chk("t6_quiet_after_reset", 32'(bad), 0);
      chk("start_count", starts, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
